// File: rtl/fpcvt_pkg.sv
// Shared float-code / linear-sample layout for the fp encode and decode paths.
// Code layout: [7] sign, [6:4] exponent, [3:0] significand.
// Magnitude = significand << exponent (max 15 << 7 = 1920, fits 11 bits).
package fpcvt_pkg;

  localparam int unsigned CODE_W   = 8;
  localparam int unsigned LIN_W    = 12;
  localparam int unsigned MAG_W    = 11;
  localparam int unsigned EXP_W    = 3;
  localparam int unsigned SIG_W    = 4;
  localparam int unsigned SIGN_BIT = 7;
  localparam int unsigned EXP_LSB  = 4;
  localparam int unsigned SIG_LSB  = 0;

  // Payload held in the first pipeline stage
  typedef struct packed {
    logic             last;
    logic             sign;
    logic [MAG_W-1:0] mag;
  } s1_payload_t;

  // Sign-magnitude to two's complement; a zero magnitude stays 0 whatever the sign
  function automatic logic [LIN_W-1:0] apply_sign(input logic sign,
                                                  input logic [MAG_W-1:0] mag);
    logic [LIN_W-1:0] ext;
    ext = {1'b0, mag};
    return sign ? LIN_W'(-ext) : ext;
  endfunction

endpackage

// File: rtl/fp_expand.sv
// Combinational float code to sign + magnitude expansion.
// Ports:
//   code_i  float code
//   sign_o  sign bit of the code
//   mag_o   significand << exponent
module fp_expand
  import fpcvt_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic              sign_o,
  output logic [MAG_W-1:0]  mag_o
);

  assign sign_o = code_i[SIGN_BIT];
  assign mag_o  = MAG_W'(code_i[SIG_LSB +: SIG_W]) << code_i[EXP_LSB +: EXP_W];

endmodule

// File: rtl/fp_decode_stream.sv
// Streaming float-code to 12-bit linear decoder, 2-stage valid/ready pipeline.
// Optional per-frame peak/count statistics enabled by macro FP_DEC_PEAK_EN.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_code/in_valid/in_last  input stream, in_ready back-pressure
//   out_lin/out_valid/out_last output stream, out_ready back-pressure
//   pk_mag/pk_count/pk_valid  completed-frame statistics (FP_DEC_PEAK_EN only)
module fp_decode_stream
  import fpcvt_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [LIN_W-1:0]  out_lin,
  output logic              out_valid,
  output logic              out_last,
`ifdef FP_DEC_PEAK_EN
  output logic [MAG_W-1:0]  pk_mag,
  output logic [CNT_W-1:0]  pk_count,
  output logic              pk_valid,
`endif
  input  logic              out_ready
);

  if (CNT_W == 0) begin : g_cnt_w_bad
    $error("CNT_W must be at least 1");
  end

  logic             exp_sign;
  logic [MAG_W-1:0] exp_mag;

  fp_expand u_expand (
    .code_i (in_code),
    .sign_o (exp_sign),
    .mag_o  (exp_mag)
  );

  s1_payload_t      s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic [LIN_W-1:0] out_lin_q, out_lin_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             s1_adv;

  // S1 may move forward when S2 is empty or being drained this cycle
  assign s1_adv   = !out_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || s1_adv);

  assign out_lin   = out_lin_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  // Pipeline next-state
  always_comb begin
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    out_lin_d   = out_lin_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_lin_d  = apply_sign(s1_q.sign, s1_q.mag);
        out_last_d = s1_q.last;
      end
    end
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = '{last: in_last, sign: exp_sign, mag: exp_mag};
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_lin_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_lin_q   <= out_lin_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef FP_DEC_PEAK_EN
  logic [MAG_W-1:0] peak_q, peak_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0] pk_mag_q, pk_mag_d;
  logic [CNT_W-1:0] pk_count_q, pk_count_d;
  logic             pk_valid_q, pk_valid_d;
  logic             out_hs;
  logic [MAG_W-1:0] cur_mag;
  logic [MAG_W-1:0] peak_new;
  logic [CNT_W-1:0] cnt_new;

  assign out_hs   = out_valid_q && out_ready;
  assign cur_mag  = out_lin_q[LIN_W-1] ? MAG_W'(-out_lin_q) : MAG_W'(out_lin_q);
  assign peak_new = (cur_mag > peak_q) ? cur_mag : peak_q;
  assign cnt_new  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  assign pk_mag   = pk_mag_q;
  assign pk_count = pk_count_q;
  assign pk_valid = pk_valid_q;

  // Frame statistics; a last-sample handshake publishes and restarts them
  always_comb begin
    peak_d     = peak_q;
    cnt_d      = cnt_q;
    pk_mag_d   = pk_mag_q;
    pk_count_d = pk_count_q;
    pk_valid_d = 1'b0;
    if (out_hs) begin
      if (out_last_q) begin
        pk_mag_d   = peak_new;
        pk_count_d = cnt_new;
        pk_valid_d = 1'b1;
        peak_d     = '0;
        cnt_d      = '0;
      end else begin
        peak_d = peak_new;
        cnt_d  = cnt_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q     <= '0;
      cnt_q      <= '0;
      pk_mag_q   <= '0;
      pk_count_q <= '0;
      pk_valid_q <= 1'b0;
    end else begin
      peak_q     <= peak_d;
      cnt_q      <= cnt_d;
      pk_mag_q   <= pk_mag_d;
      pk_count_q <= pk_count_d;
      pk_valid_q <= pk_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_fp_decode_stream.sv
// Directed bench for fp_decode_stream: decode values, latency, back-pressure,
// mid-stream reset and (with FP_DEC_PEAK_EN) frame peak statistics.
module tb_fp_decode_stream;

  localparam int unsigned CNT_W = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  in_code;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [11:0] out_lin;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
`ifdef FP_DEC_PEAK_EN
  logic [10:0]      pk_mag;
  logic [CNT_W-1:0] pk_count;
  logic             pk_valid;
`endif

  int n_chk = 0;
  int n_bad = 0;

  fp_decode_stream #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_lin   (out_lin),
    .out_valid (out_valid),
    .out_last  (out_last),
`ifdef FP_DEC_PEAK_EN
    .pk_mag    (pk_mag),
    .pk_count  (pk_count),
    .pk_valid  (pk_valid),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample with out_ready high: visible exactly 2 edges after acceptance
  task automatic send_one(input logic [7:0] code, input logic [11:0] exp_lin);
    in_code  = code;
    in_valid = 1'b1;
    in_last  = 1'b1;
    #1;
    chk("dec_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("dec_lat1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("dec_valid", 32'(out_valid), 32'd1);
    chk("dec_lin", 32'(out_lin), 32'(exp_lin));
    chk("dec_last", 32'(out_last), 32'd1);
    tick();
  endtask

  // Stream codes 0x10..0x1F; expected output k is 2*k
  task automatic run_stream(input bit stall, output int iters);
    int          idx;
    int          k;
    int          occ;
    bit          held;
    logic [11:0] hv;
    idx   = 0;
    k     = 0;
    occ   = 0;
    held  = 1'b0;
    hv    = '0;
    iters = 0;
    while (k < 16 && iters < 400) begin
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_last   = 1'b0;
      if (idx < 16) begin
        in_valid = 1'b1;
        in_code  = 8'(8'h10 + idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_lin", 32'(out_lin), 32'(hv));
      end
      chk("bp_in_ready", 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        chk("bp_data", 32'(out_lin), 32'(2 * k));
        k++;
        occ--;
      end
      held = out_valid && !out_ready;
      hv   = out_lin;
      if (in_valid && in_ready) begin
        idx++;
        occ++;
      end
      tick();
      iters++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(k), 32'd16);
  endtask

`ifdef FP_DEC_PEAK_EN
  // Send n codes back-to-back as one frame, then look for exactly one pk_valid pulse
  task automatic peak_frame(input int n, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [10:0] exp_mag,
                            input logic [15:0] exp_cnt);
    logic [7:0]       codes [3];
    int               pulses;
    logic [10:0]      gm;
    logic [CNT_W-1:0] gc;
    codes[0]  = c0;
    codes[1]  = c1;
    codes[2]  = c2;
    pulses    = 0;
    gm        = '0;
    gc        = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < n) begin
        in_valid = 1'b1;
        in_code  = codes[c];
        in_last  = (c == n - 1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      tick();
      if (pk_valid) begin
        pulses++;
        gm = pk_mag;
        gc = pk_count;
      end
    end
    chk("pk_pulses", 32'(pulses), 32'd1);
    chk("pk_mag", 32'(gm), 32'(exp_mag));
    chk("pk_count", 32'(gc), 32'(exp_cnt));
  endtask
`endif

  initial begin
    int it;
    rst       = 1'b1;
    in_code   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_lin", 32'(out_lin), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef FP_DEC_PEAK_EN
    chk("rst_pk_valid", 32'(pk_valid), 32'd0);
    chk("rst_pk_mag", 32'(pk_mag), 32'd0);
    chk("rst_pk_count", 32'(pk_count), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    send_one(8'h00, 12'h000);
    send_one(8'h25, 12'h014);
    send_one(8'h7F, 12'h780);
    send_one(8'hA5, 12'hFEC);
    send_one(8'hFF, 12'h880);
    send_one(8'h80, 12'h000);

    run_stream(1'b0, it);
    chk("bp_nostall_iters", 32'(it), 32'd18);
    run_stream(1'b1, it);
    tick();

    // Reset with two samples in flight
    out_ready = 1'b1;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    in_code   = 8'h7F;
    tick();
    in_code = 8'h25;
    tick();
    in_valid = 1'b0;
    #1;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_lin", 32'(out_lin), 32'h780);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end

`ifdef FP_DEC_PEAK_EN
    peak_frame(3, 8'h21, 8'hFF, 8'h35, 11'd1920, 16'd3);
    peak_frame(1, 8'h12, 8'h00, 8'h00, 11'd4, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_decode_stream.md
FP_DECODE_STREAM -- requirements
Module: fp_decode_stream

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the per-frame sample count.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_code  input  8  float code: [7] sign, [6:4] exponent, [3:0] significand.
REQ-005 SHALL have port in_valid  input  1  in_code/in_last valid.
REQ-006 SHALL have port in_last  input  1  marks the final sample of a frame.
REQ-007 SHALL have port in_ready  output  1  block accepts the input this cycle.
REQ-008 SHALL have port out_lin  output  12  decoded two's-complement linear sample.
REQ-009 SHALL have port out_valid  output  1  out_lin/out_last valid.
REQ-010 SHALL have port out_last  output  1  in_last carried through with its sample.
REQ-011 SHALL have port out_ready  input  1  downstream accepts.
REQ-012 SHALL have port pk_mag  output  11  peak magnitude of the completed frame (FP_DEC_PEAK_EN only).
REQ-013 SHALL have port pk_count  output  CNT_W  sample count of the completed frame (FP_DEC_PEAK_EN only).
REQ-014 SHALL have port pk_valid  output  1  one-cycle strobe qualifying pk_mag/pk_count (FP_DEC_PEAK_EN only).

Function
REQ-015 SHALL transfer on the input when in_valid and in_ready are both high, and on the output when out_valid and out_ready are both high.
REQ-016 SHALL be a 2-stage pipeline: S1 registers magnitude = significand << exponent (11 bits, max 1920) plus sign and last; S2 registers out_lin = sign ? -magnitude : magnitude.
REQ-017 SHALL decode a sign-set, zero-magnitude code (e.g. 0x80) to 0x000, never a negative-zero artefact.
REQ-018 SHALL have latency of 2 cycles from input handshake to out_valid when out_ready is held high.
REQ-019 SHALL sustain one sample per cycle when out_ready is held high.
REQ-020 SHALL drive in_ready = !S1_valid || S1_advance, where S1_advance = !S2_valid || out_ready; in_ready SHALL NOT depend combinationally on in_valid.
REQ-021 SHALL hold out_lin, out_last stable while out_valid is high and out_ready is low, and SHALL drop no samples and duplicate none under any backpressure pattern.
REQ-022 SHALL allow an input and an output handshake in the same cycle when the pipe is full, without a bubble.

Reset
REQ-023 SHALL, while rst is high, clear S1/S2 valid bits, out_valid=0, out_lin=0, out_last=0, pk_valid=0, pk_mag=0, pk_count=0, peak and count accumulators=0.
REQ-024 SHALL drive in_ready=0 during reset and SHALL drive in_ready=1 on the first cycle after rst deasserts.
REQ-025 SHALL discard all in-flight samples and any partial frame statistics when rst asserts mid-operation.

Configuration
REQ-026 SHALL, with macro FP_DEC_PEAK_EN defined, track the running max of |out_lin| and the count of output-accepted samples.
REQ-027 SHALL, on the output handshake of a sample with out_last=1, pulse pk_valid for exactly one cycle next cycle, with pk_mag = max including that sample and pk_count = frame count including that sample, then restart both accumulators at zero.
REQ-028 SHALL saturate pk_count at 2^CNT_W-1 and never wrap.
REQ-029 SHALL, without FP_DEC_PEAK_EN, omit pk_mag, pk_count and pk_valid and all their logic; pipeline behaviour SHALL be unchanged.

Structure
REQ-030 SHALL take the float field positions (sign bit 7, exponent [6:4], significand [3:0]) and widths (8-bit code, 12-bit linear, 11-bit magnitude) from a shared package fpcvt_pkg, which the encoder path also uses.
REQ-031 SHALL place the combinational code-to-magnitude shift in sub-module fp_expand; handshake and peak logic SHALL stay in fp_decode_stream.

Verification
REQ-032 SHALL cover decode: 0x00, 0x25, 0x7F, 0xA5, 0xFF with out_ready=1 -> out_lin 0x000, 0x014, 0x780, 0xFEC, 0x880 respectively, each 2 cycles after acceptance.
REQ-033 SHALL cover negative zero: 0x80 -> out_lin 0x000.
REQ-034 SHALL cover backpressure: stream 0x10..0x1F with out_ready toggled by 1-in-3 random stalls -> all 16 outputs in order (0x000..0x00F scaled by 2), values held stable during stalls, in_ready low only while the pipe is full.
REQ-035 SHALL cover the peak path: frame of codes 0x21, 0xFF, 0x35 with last on 0x35 -> pk_valid one cycle, pk_mag=1920, pk_count=3; next frame's count restarts at 1.
REQ-036 SHALL cover reset mid-stream: assert rst with 2 samples in flight -> out_valid=0 next cycle, no stale output after release, pk_count of the following frame excludes pre-reset samples.
